flash_cmd_trace: RTL and testbench

Command trace buffer for the DUT flash emulator. Sits directly downstream of the flash interface: it consumes the per-command monitor strobe (`mon_cmd` / `mon_stb`) produced by the emulator and timestamps each opcode. It also queues each entry in a FIFO that the host drains over the same single-cycle-ack Wishbone-style bus used by the other DUT interface blocks. This lets bring-up software see the exact opcode sequence and timing the DUT issued at boot, not just a count.

---
 rtl/flash_cmd_trace.sv | 148 ++++++++++++++
 tb/tb_flash_cmd_trace.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/flash_cmd_trace.sv
// Timestamped opcode trace FIFO drained over a single-cycle-ack bus; optional opcode filter under FLASH_CMD_TRACE_FILTER_EN.
// Pushes land one cycle after the strobe, bus effects land in the ack cycle; strobes into a full FIFO are dropped and counted.
module flash_cmd_trace #(
    parameter int DEPTH_LOG2 = 6,
    parameter int TS_WIDTH   = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  mon_cmd,
    input  logic        mon_stb,
    input  logic [1:0]  wb_addr,
    output logic [31:0] wb_rdata,
    input  logic [31:0] wb_wdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [TS_WIDTH-1:0]   ts;
    logic [23:0]           ts_ext;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [7:0]            drop_cnt;
    logic                  ovf;
    logic                  enable;
    logic                  empty;
    logic                  full;
    logic                  ctrl_wr;
    logic                  clr;
    logic                  pop;
    logic                  eligible;
    logic                  push;
    logic                  drop;
    logic                  filt_ok;
    logic [31:0]           filt_rd;
    logic [31:0]           status;
    logic [31:0]           rd_val;

    assign ts_ext = 24'(ts);
    assign empty  = (level == '0);
    // level never exceeds DEPTH, so its top bit alone marks full
    assign full   = level[DEPTH_LOG2];

    // Bus side effects are applied at the edge that closes the ack cycle.
    assign ctrl_wr  = wb_ack & wb_we & (wb_addr == 2'd0);
    assign clr      = ctrl_wr & wb_wdata[1];
    assign pop      = wb_ack & ~wb_we & (wb_addr == 2'd1) & ~empty;
    assign eligible = mon_stb & enable & ~clr & filt_ok;
    assign push     = eligible & (~full | pop);
    assign drop     = eligible & full & ~pop;

`ifdef FLASH_CMD_TRACE_FILTER_EN
    logic       filt_en;
    logic [7:0] filt_mask;
    logic [7:0] filt_match;
    logic       unused_wdata;

    assign filt_ok      = ~filt_en | ((mon_cmd & filt_mask) == (filt_match & filt_mask));
    assign filt_rd      = {15'b0, filt_en, filt_mask, filt_match};
    assign unused_wdata = ^wb_wdata[31:17];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_en    <= 1'b0;
            filt_mask  <= 8'h00;
            filt_match <= 8'h00;
        end else if (wb_ack && wb_we && wb_addr == 2'd2) begin
            filt_en    <= wb_wdata[16];
            filt_mask  <= wb_wdata[15:8];
            filt_match <= wb_wdata[7:0];
        end
    end
`else
    logic unused_wdata;

    assign filt_ok      = 1'b1;
    assign filt_rd      = 32'h0;
    assign unused_wdata = ^wb_wdata[31:2];
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {mon_cmd, ts_ext};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= 8'h00;
            ovf      <= 1'b0;
            enable   <= 1'b1;
            wb_ack   <= 1'b0;
        end else begin
            wb_ack <= wb_cyc & ~wb_ack;
            ts     <= clr ? '0 : ts + 1'b1;
            if (ctrl_wr) begin
                enable <= wb_wdata[0];
            end
            if (clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                drop_cnt <= 8'h00;
                ovf      <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    level <= level + 1'b1;
                end else if (pop && !push) begin
                    level <= level - 1'b1;
                end
                if (drop) begin
                    ovf <= 1'b1;
                    if (drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign status = {empty, full, ovf, enable, 4'b0, drop_cnt, 16'(level)};

    always_comb begin
        rd_val = 32'h0;
        case (wb_addr)
            2'd0:    rd_val = status;
            2'd1:    rd_val = empty ? 32'h0 : mem[rd_ptr];
            2'd2:    rd_val = filt_rd;
            default: rd_val = 32'h0;
        endcase
    end

    assign wb_rdata = (wb_ack && !wb_we) ? rd_val : 32'h0;

endmodule

// File: tb/tb_flash_cmd_trace.sv
// Directed bench for flash_cmd_trace with a 4-entry FIFO and 8-bit timestamp.
module tb_flash_cmd_trace;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  mon_cmd;
    logic        mon_stb;
    logic [1:0]  wb_addr;
    logic [31:0] wb_rdata;
    logic [31:0] wb_wdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;

    int total = 0;
    int bad   = 0;
    logic [31:0] q;

    flash_cmd_trace #(.DEPTH_LOG2(2), .TS_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mon_cmd  (mon_cmd),
        .mon_stb  (mon_stb),
        .wb_addr  (wb_addr),
        .wb_rdata (wb_rdata),
        .wb_wdata (wb_wdata),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge; the access occupies two cycles.
    task automatic bus(input logic [1:0] a, input logic we, input logic [31:0] d, output logic [31:0] r);
        wb_cyc = 1'b1; wb_addr = a; wb_we = we; wb_wdata = d;
        @(negedge clk);
        chk("ack", {31'b0, wb_ack}, 32'h1);
        r = wb_rdata;
        @(negedge clk);
        wb_cyc = 1'b0; wb_we = 1'b0; wb_wdata = 32'h0;
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        logic [31:0] r;
        bus(a, 1'b0, 32'h0, r);
        chk(tag, r, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(a, 1'b1, d, r);
    endtask

    task automatic strobe(input logic [7:0] c);
        mon_stb = 1'b1; mon_cmd = c;
        @(negedge clk);
        mon_stb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mon_cmd = 8'h00; mon_stb = 1'b0;
        wb_addr = 2'd0; wb_wdata = 32'h0; wb_we = 1'b0; wb_cyc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, wb_ack}, 32'h0);
        chk("rst_rdata", wb_rdata, 32'h0);
        rst_n = 1'b1;

        // Basic capture: ts is 0 in the cycle of reset release
        repeat (10) @(negedge clk);
        strobe(8'hAB);
        repeat (9) @(negedge clk);
        strobe(8'h03);
        rd(2'd0, "basic_status", 32'h10000002);
        rd(2'd1, "basic_pop0", 32'hAB00000A);
        rd(2'd1, "basic_pop1", 32'h03000014);
        rd(2'd1, "basic_pop_empty", 32'h00000000);
        rd(2'd0, "basic_status_empty", 32'h90000000);
        rd(2'd3, "addr3_read", 32'h00000000);

        // Overflow: 7 strobes into 4 entries
        for (int i = 0; i < 7; i++) strobe(8'h10 + 8'(i));
        rd(2'd0, "ovf_status", 32'h70030004);
        bus(2'd1, 1'b0, 32'h0, q);
        chk("ovf_pop_opcode", {24'h0, q[31:24]}, 32'h10);
        rd(2'd0, "ovf_status_after_pop", 32'h30030003);
        wr(2'd0, 32'h3);
        rd(2'd0, "ovf_cleared", 32'h90000000);

        // Push + pop on full; ts was zeroed by the clear above
        wr(2'd0, 32'h3);
        for (int i = 0; i < 4; i++) strobe(8'h20 + 8'(i));
        wb_cyc = 1'b1; wb_addr = 2'd1; wb_we = 1'b0;
        @(negedge clk);
        mon_stb = 1'b1; mon_cmd = 8'h24;
        chk("pp_full_pop", wb_rdata, 32'h20000000);
        @(negedge clk);
        mon_stb = 1'b0; wb_cyc = 1'b0;
        rd(2'd0, "pp_full_status", 32'h50000004);
        rd(2'd1, "pp_pop1", 32'h21000001);
        rd(2'd1, "pp_pop2", 32'h22000002);
        rd(2'd1, "pp_pop3", 32'h23000003);
        rd(2'd1, "pp_pop4", 32'h24000005);

        // Clear in the same cycle as a strobe
        wb_cyc = 1'b1; wb_addr = 2'd0; wb_we = 1'b1; wb_wdata = 32'h3;
        @(negedge clk);
        mon_stb = 1'b1; mon_cmd = 8'h55;
        @(negedge clk);
        mon_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        rd(2'd0, "clr_vs_stb", 32'h90000000);

        // Disabled strobes are ignored, not dropped
        wr(2'd0, 32'h0);
        for (int i = 0; i < 5; i++) strobe(8'h66);
        rd(2'd0, "disabled_status", 32'h80000000);
        wr(2'd0, 32'h1);

        // drop_cnt saturates
        for (int i = 0; i < 300; i++) strobe(8'h40);
        rd(2'd0, "drop_sat", 32'h70FF0004);
        wr(2'd0, 32'h3);

        // Timestamp wraps modulo 256
        repeat (259) @(negedge clk);
        strobe(8'h77);
        rd(2'd1, "ts_wrap", 32'h77000003);

        // Filter register
        wr(2'd2, 32'h0001FF0B);
        strobe(8'h0B); strobe(8'h03); strobe(8'h0B);
        wr(2'd1, 32'hDEADBEEF);
        wr(2'd3, 32'hDEADBEEF);
        rd(2'd3, "addr3_after_write", 32'h00000000);
`ifdef FLASH_CMD_TRACE_FILTER_EN
        rd(2'd2, "filter_read", 32'h0001FF0B);
        rd(2'd0, "filter_status", 32'h10000002);
        bus(2'd1, 1'b0, 32'h0, q);
        chk("filter_pop0", {24'h0, q[31:24]}, 32'h0B);
        bus(2'd1, 1'b0, 32'h0, q);
        chk("filter_pop1", {24'h0, q[31:24]}, 32'h0B);
        wr(2'd2, 32'h0);
`else
        rd(2'd2, "filter_read", 32'h00000000);
        rd(2'd0, "filter_status", 32'h10000003);
        bus(2'd1, 1'b0, 32'h0, q);
        chk("filter_pop0", {24'h0, q[31:24]}, 32'h0B);
        bus(2'd1, 1'b0, 32'h0, q);
        chk("filter_pop1", {24'h0, q[31:24]}, 32'h03);
        bus(2'd1, 1'b0, 32'h0, q);
        chk("filter_pop2", {24'h0, q[31:24]}, 32'h0B);
`endif

        // Async reset with level 3 and a read pending
        strobe(8'h31); strobe(8'h32); strobe(8'h33);
        rd(2'd0, "pre_reset_status", 32'h10000003);
        wb_cyc = 1'b1; wb_addr = 2'd1; wb_we = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ack", {31'b0, wb_ack}, 32'h0);
        chk("mid_rst_rdata", wb_rdata, 32'h0);
        wb_cyc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd(2'd0, "post_rst_status", 32'h90000000);
        // Pop on empty with a push in the ack cycle; ts is 3 there
        wb_cyc = 1'b1; wb_addr = 2'd1; wb_we = 1'b0;
        @(negedge clk);
        mon_stb = 1'b1; mon_cmd = 8'h99;
        chk("pp_empty_pop", wb_rdata, 32'h0);
        @(negedge clk);
        mon_stb = 1'b0; wb_cyc = 1'b0;
        rd(2'd0, "pp_empty_status", 32'h10000001);
        rd(2'd1, "post_rst_ts", 32'h99000003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
